// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  // A beat carrying one of these cycle types ends a transfer, so the bus
  // may change hands right after it is acknowledged.
  function automatic logic cti_boundary(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic/registered-feedback bus bundle.
interface wshb_if;
  import wshb_arb_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_ms;
  logic [DAT_W-1:0] dat_sm;
  logic [SEL_W-1:0] sel;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic             ack;
  logic             err;
  logic             rty;

  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  input  dat_sm, ack, err, rty);
  modport slave  (input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_arb_hold_cnt.sv
// Saturating counter measuring how long m0 has been kept waiting by m1.
module wshb_arb_hold_cnt #(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_max
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_max = (cnt_q == CNT_W'(MAX_HOLD));

  // Clear has priority; count up while enabled and stick at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master / one-slave Wishbone arbiter: m0 (VGA reader) has priority,
// m1 (pattern writer) may be preempted at transfer boundaries once m0 has
// waited MAX_HOLD cycles.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 64,
  parameter bit M1_PREEMPT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  wshb_if.slave      m0,
  wshb_if.slave      m1,
  wshb_if.master     s,
  output logic [1:0] gnt
);

  state_t state_q;
  state_t state_d;

  logic hold_clr;
  logic hold_en;
  logic hold_at_max;
  logic preempt;

  logic             s_cyc;
  logic             s_stb;
  logic             s_we;
  logic [ADR_W-1:0] s_adr;
  logic [DAT_W-1:0] s_dat_ms;
  logic [SEL_W-1:0] s_sel;
  logic [2:0]       s_cti;
  logic [1:0]       s_bte;
  logic             m0_ack, m0_err, m0_rty;
  logic             m1_ack, m1_err, m1_rty;

  // m1 yields only on an acknowledged beat that closes a transfer, so a
  // stalled m1 simply retries its pending beat when regranted.
  assign preempt = M1_PREEMPT && m0.cyc && hold_at_max && s.ack &&
                   cti_boundary(s_cti);

  // Hold time only accrues while m1 owns the bus and m0 is asking for it.
  assign hold_en  = (state_q == GNT1) && m0.cyc;
  assign hold_clr = (state_q != GNT1) || (state_d != GNT1) || !m0.cyc;

  wshb_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (hold_clr),
    .en     (hold_en),
    .at_max (hold_at_max)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: m0 wins ties, handovers go straight to the other master.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0.cyc)      state_d = GNT0;
        else if (m1.cyc) state_d = GNT1;
      end
      GNT0: begin
        if (!m0.cyc) state_d = m1.cyc ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1.cyc)     state_d = m0.cyc ? GNT0 : IDLE;
        else if (preempt) state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux from registered state; responses reach only the granted
  // master, and only while it still holds cyc so an aborted beat's ack is lost.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rty   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rty   = 1'b0;
    unique case (state_q)
      GNT0: begin
        s_cyc    = m0.cyc;
        s_stb    = m0.stb;
        s_we     = m0.we;
        s_adr    = m0.adr;
        s_dat_ms = m0.dat_ms;
        s_sel    = m0.sel;
        s_cti    = m0.cti;
        s_bte    = m0.bte;
        m0_ack   = s.ack & m0.cyc;
        m0_err   = s.err & m0.cyc;
        m0_rty   = s.rty & m0.cyc;
      end
      GNT1: begin
        s_cyc    = m1.cyc;
        s_stb    = m1.stb;
        s_we     = m1.we;
        s_adr    = m1.adr;
        s_dat_ms = m1.dat_ms;
        s_sel    = m1.sel;
        s_cti    = m1.cti;
        s_bte    = m1.bte;
        m1_ack   = s.ack & m1.cyc;
        m1_err   = s.err & m1.cyc;
        m1_rty   = s.rty & m1.cyc;
      end
      default: ;
    endcase
  end

  assign s.cyc    = s_cyc;
  assign s.stb    = s_stb;
  assign s.we     = s_we;
  assign s.adr    = s_adr;
  assign s.dat_ms = s_dat_ms;
  assign s.sel    = s_sel;
  assign s.cti    = s_cti;
  assign s.bte    = s_bte;

  assign m0.ack    = m0_ack;
  assign m0.err    = m0_err;
  assign m0.rty    = m0_rty;
  assign m1.ack    = m1_ack;
  assign m1.err    = m1_err;
  assign m1.rty    = m1_rty;
  assign m0.dat_sm = s.dat_sm;
  assign m1.dat_sm = s.dat_sm;

  assign gnt = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter with MAX_HOLD=4: two master drivers,
// a slave model with programmable ack delay and a transfer log.
module tb_wshb_arbiter;
  import wshb_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gnt;

  wshb_if m0_if ();
  wshb_if m1_if ();
  wshb_if s_if ();

  wshb_arbiter #(
    .MAX_HOLD   (4),
    .M1_PREEMPT (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .gnt   (gnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Slave model: ack once stb has been waiting ack_dly cycles.
  int unsigned ack_dly = 0;
  int unsigned wait_q  = 0;
  assign s_if.ack    = s_if.cyc && s_if.stb && (wait_q >= ack_dly);
  assign s_if.err    = 1'b0;
  assign s_if.rty    = 1'b0;
  assign s_if.dat_sm = {16'hD000, s_if.adr[15:0]};

  always @(posedge clk) begin
    if (s_if.cyc && s_if.stb && !s_if.ack) wait_q <= wait_q + 1;
    else                                   wait_q <= 0;
  end

  // Log of completed slave beats and per-master ack counts.
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  int m0_acks = 0;
  int m1_acks = 0;

  always @(negedge clk) begin
    if (s_if.cyc === 1'b1 && s_if.stb === 1'b1 && s_if.ack === 1'b1) begin
      log_adr.push_back(s_if.adr);
      log_dat.push_back(s_if.dat_ms);
      log_we.push_back(s_if.we);
    end
    if (m0_if.ack === 1'b1) m0_acks <= m0_acks + 1;
    if (m1_if.ack === 1'b1) m1_acks <= m1_acks + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dat_of(input logic [31:0] adr);
    return 32'hA500_0000 ^ adr;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic m0_idle();
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = '0;
    m0_if.dat_ms = '0; m0_if.sel = '0; m0_if.cti = '0; m0_if.bte = '0;
  endtask

  task automatic m1_idle();
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.adr = '0;
    m1_if.dat_ms = '0; m1_if.sel = '0; m1_if.cti = '0; m1_if.bte = '0;
  endtask

  task automatic m0_read(input logic [31:0] adr);
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 0; m0_if.adr = adr;
    m0_if.dat_ms = '0; m0_if.sel = 4'hF; m0_if.cti = CTI_CLASSIC; m0_if.bte = 2'b00;
  endtask

  task automatic m1_write(input logic [31:0] adr, input logic [2:0] cti);
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = 1; m1_if.adr = adr;
    m1_if.dat_ms = dat_of(adr); m1_if.sel = 4'hF; m1_if.cti = cti; m1_if.bte = 2'b00;
  endtask

  // Wait (bounded) until the chosen master sees ack; return just after the
  // completing edge.
  task automatic wait_ack(input int who, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((who == 0 && m0_if.ack === 1'b1) || (who == 1 && m1_if.ack === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic m1_stream(input logic [31:0] base, input int n, input bit burst);
    logic [2:0] cti;
    for (int i = 0; i < n; i++) begin
      cti = !burst ? CTI_CLASSIC : ((i == n - 1) ? CTI_EOB : CTI_INCR);
      m1_write(base + 32'(i), cti);
      wait_ack(1, "m1_beat_ack");
    end
    m1_idle();
  endtask

  int l0, a0, a1, n, wi, rd;
  logic order_ok;

  initial begin
    rst_n = 1'b0;
    m0_idle();
    m1_idle();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_s_cyc", 32'(s_if.cyc), 32'd0);
    chk("rst_m0_ack", 32'(m0_if.ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_if.ack), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_grant", 32'(gnt), 32'd0);
    chk("idle_s_cyc", 32'(s_if.cyc), 32'd0);

    // Simultaneous requests: m0 wins, then direct handover to m1
    ack_dly = 2;
    a1 = m1_acks;
    m0_read(32'h100);
    m1_write(32'h200, CTI_CLASSIC);
    @(posedge clk); #1;
    chk("sim_gnt_m0", 32'(gnt), 32'h1);
    chk("sim_s_adr", s_if.adr, 32'h100);
    chk("sim_dat_sm_m0", m0_if.dat_sm, 32'hD000_0100);
    chk("sim_dat_sm_m1", m1_if.dat_sm, 32'hD000_0100);
    wait_ack(0, "sim_m0_ack");
    m0_idle();
    chk("sim_m1_no_ack", 32'(m1_acks - a1), 32'd0);
    @(posedge clk); #1;
    chk("sim_gnt_m1", 32'(gnt), 32'h2);
    chk("sim_s_adr_m1", s_if.adr, 32'h200);
    wait_ack(1, "sim_m1_ack");
    m1_idle();
    repeat (2) @(posedge clk);
    #1;

    // Solo m1: 8 classic writes acked every cycle
    ack_dly = 0;
    l0 = log_adr.size();
    a0 = m0_acks;
    a1 = m1_acks;
    m1_stream(32'h300, 8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("solo_m1_acks", 32'(m1_acks - a1), 32'd8);
    chk("solo_log_len", 32'(log_adr.size() - l0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("solo_adr", log_adr[l0 + i], 32'h300 + 32'(i));
      chk("solo_dat", log_dat[l0 + i], dat_of(32'h300 + 32'(i)));
    end
    chk("solo_m0_no_ack", 32'(m0_acks - a0), 32'd0);

    // Preemption of a classic m1 stream
    l0 = log_adr.size();
    a1 = m1_acks;
    n = 0;
    fork
      m1_stream(32'h500, 16, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        m0_read(32'h400);
        for (int k = 1; k <= 12; k++) begin
          @(posedge clk); #1;
          if (gnt === 2'b01) begin
            n = k;
            break;
          end
        end
        chk("pre_latency", 32'(n), 32'd5);
        chk("pre_m1_stalled", 32'(m1_if.ack), 32'd0);
        chk("pre_m0_acked", 32'(m0_if.ack), 32'd1);
        wait_ack(0, "pre_m0_ack");
        m0_idle();
        @(posedge clk); #1;
        chk("pre_regrant", 32'(gnt), 32'h2);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    wi = 0;
    rd = 0;
    order_ok = 1'b1;
    for (int j = l0; j < log_adr.size(); j++) begin
      if (log_we[j]) begin
        if (log_adr[j] !== 32'h500 + 32'(wi) || log_dat[j] !== dat_of(32'h500 + 32'(wi)))
          order_ok = 1'b0;
        wi++;
      end else begin
        rd++;
      end
    end
    chk("pre_m1_writes", 32'(wi), 32'd16);
    chk("pre_m1_order", 32'(order_ok), 32'd1);
    chk("pre_m0_reads", 32'(rd), 32'd1);
    chk("pre_m1_acks", 32'(m1_acks - a1), 32'd16);

    // Burst guard: m0 must wait for the end-of-burst beat
    l0 = log_adr.size();
    a1 = m1_acks;
    n = -1;
    fork
      m1_stream(32'h600, 8, 1'b1);
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (m1_acks - a1 >= 1) break;
        end
        m0_read(32'h410);
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          if (gnt === 2'b01) begin
            n = m1_acks - a1;
            break;
          end
        end
        chk("burst_beats_before_m0", 32'(n), 32'd8);
        wait_ack(0, "burst_m0_ack");
        m0_idle();
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("burst_log_len", 32'(log_adr.size() - l0), 32'd9);
    chk("burst_last_beat", log_adr[l0 + 7], 32'h607);
    chk("burst_then_m0", log_adr[l0 + 8], 32'h410);

    // Abort: m1 drops cyc without ack, grant is released
    ack_dly = 10;
    m1_write(32'h780, CTI_CLASSIC);
    @(posedge clk); #1;
    chk("abort_gnt_m1", 32'(gnt), 32'h2);
    m1_idle();
    @(posedge clk); #1;
    chk("abort_released", 32'(gnt), 32'd0);

    // Reset during GNT1 with stb high
    m1_write(32'h700, CTI_CLASSIC);
    @(posedge clk); #1;
    chk("r1_gnt_m1", 32'(gnt), 32'h2);
    chk("r1_s_cyc_hi", 32'(s_if.cyc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r1_s_cyc", 32'(s_if.cyc), 32'd0);
    chk("r1_s_stb", 32'(s_if.stb), 32'd0);
    chk("r1_gnt", 32'(gnt), 32'd0);
    chk("r1_m1_ack", 32'(m1_if.ack), 32'd0);
    m1_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("r1_idle_after", 32'(gnt), 32'd0);

    // Reset while m0 is being acknowledged
    ack_dly = 0;
    m0_read(32'h800);
    @(posedge clk); #1;
    chk("r0_m0_ack_before", 32'(m0_if.ack), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r0_m0_ack", 32'(m0_if.ack), 32'd0);
    chk("r0_s_cyc", 32'(s_if.cyc), 32'd0);
    chk("r0_gnt", 32'(gnt), 32'd0);
    m0_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("r0_no_grant", 32'(gnt), 32'd0);
    m0_read(32'h810);
    @(posedge clk); #1;
    chk("r0_regrant_m0", 32'(gnt), 32'h1);
    wait_ack(0, "r0_m0_final_ack");
    m0_idle();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
